// File: rtl/sample_serializer.sv
`default_nettype none
// ============================================================================
// Module  : sample_serializer
// Brief   : Splits show-ahead FIFO records into a little-endian byte stream.
// Revision: 1.0 - initial release
// ============================================================================
module sample_serializer #(
    parameter int RECORD_BYTES = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [8*RECORD_BYTES-1:0] rec_data,
    input  logic                      rec_valid,
    output logic                      rec_ack,
    output logic [7:0]                sample,
    output logic                      sample_rdy,
    input  logic                      sample_ack,
    output logic                      busy,
    output logic [31:0]               records_sent
);

    localparam int               IDX_W    = $clog2(RECORD_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RECORD_BYTES - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t                    state_q;
    logic [8*RECORD_BYTES-1:0] hold_q;
    logic [IDX_W-1:0]          idx_q;
    logic                      sample_rdy_q;
    logic [31:0]               records_sent_q;

    logic                      w_xfer;
    logic                      w_last;
    logic                      w_load;
    logic [7:0]                w_sample;

    assign w_xfer = sample_rdy_q && sample_ack;
    assign w_last = (idx_q == LAST_IDX);

    // The pop strobe must coincide with the latch edge of a show-ahead FIFO,
    // so it is decoded from the current state rather than registered.
    assign w_load = !reset && enable && rec_valid &&
                    ((state_q == S_IDLE) || (w_xfer && w_last));

    always_comb begin
        w_sample = 8'h00;
        for (int i = 0; i < RECORD_BYTES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                w_sample = hold_q[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            hold_q         <= '0;
            idx_q          <= '0;
            sample_rdy_q   <= 1'b0;
            records_sent_q <= 32'd0;
        end else begin
            if (w_load) begin
                hold_q <= rec_data;
            end
            // Index returns to zero after the final byte, ready for the next load.
            if (w_xfer) begin
                idx_q <= w_last ? '0 : idx_q + 1'b1;
            end
            if (w_xfer && w_last) begin
                records_sent_q <= records_sent_q + 32'd1;
            end
            case (state_q)
                S_IDLE: begin
                    if (w_load) begin
                        state_q      <= S_SEND;
                        sample_rdy_q <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (w_xfer && w_last && !w_load) begin
                        state_q      <= S_IDLE;
                        sample_rdy_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    sample_rdy_q <= 1'b0;
                end
            endcase
        end
    end

    assign rec_ack      = w_load;
    assign sample       = w_sample;
    assign sample_rdy   = sample_rdy_q;
    assign busy         = (state_q == S_SEND);
    assign records_sent = records_sent_q;

endmodule
`default_nettype wire

// File: tb/tb_sample_serializer.sv
`default_nettype none
// ============================================================================
// Module  : tb_sample_serializer
// Brief   : Scoreboard bench for sample_serializer with a FIFO model upstream.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sample_serializer;

    localparam int RB = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [8*RB-1:0] rec_data;
    logic          rec_valid;
    logic          rec_ack;
    logic [7:0]    sample;
    logic          sample_rdy;
    logic          sample_ack;
    logic          busy;
    logic [31:0]   records_sent;

    logic [8*RB-1:0] fifo_mem [0:31];
    int unsigned     wp = 0;
    int unsigned     rp = 0;
    logic            pop_flag = 1'b0;

    logic [7:0]  exp_q[$];
    int          ack_cyc[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc = 0;
    int          ack_cnt = 0;
    int          bytes_xfer = 0;
    int          rdy_run = 0;
    int          max_run = 0;
    int          base_ack;
    int          base_bytes;
    logic        stall_pend = 1'b0;
    logic [7:0]  stall_val = 8'h00;

    always #5 clk = ~clk;

    assign rec_valid = (wp != rp);
    assign rec_data  = fifo_mem[rp[4:0]];

    sample_serializer #(.RECORD_BYTES(RB)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .rec_data     (rec_data),
        .rec_valid    (rec_valid),
        .rec_ack      (rec_ack),
        .sample       (sample),
        .sample_rdy   (sample_rdy),
        .sample_ack   (sample_ack),
        .busy         (busy),
        .records_sent (records_sent)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    task automatic push_rec(input logic [8*RB-1:0] r);
        fifo_mem[wp[4:0]] = r;
        wp = wp + 1;
        for (int i = 0; i < RB; i++) exp_q.push_back(r[8*i +: 8]);
    endtask

    task automatic wait_done(input int n_left, input bit rnd_ack);
        int k;
        for (k = 0; k < 400; k++) begin
            @(posedge clk); #1;
            if (rnd_ack) sample_ack = 1'($urandom_range(0, 1));
            if (!sample_rdy && !rec_ack && exp_q.size() == n_left) break;
        end
        if (k == 400) begin
            n_checks++; n_fail++;
            $display("FAIL wait_done: timeout, %0d bytes pending, required %0d", exp_q.size(), n_left);
        end
        sample_ack = 1'b1;
    endtask

    task automatic wait_bytes(input int target);
        int k;
        for (k = 0; k < 400; k++) begin
            @(posedge clk);
            if (bytes_xfer >= target) break;
        end
        if (k == 400) begin
            n_checks++; n_fail++;
            $display("FAIL wait_bytes: timeout, transferred %0d required %0d", bytes_xfer, target);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pop_flag) rp <= rp + 1;
    end

    // Monitor: FIFO pops, byte scoreboard, stall stability and run length.
    always @(negedge clk) begin
        pop_flag = rec_ack;
        if (rec_ack) begin
            ack_cnt++;
            ack_cyc.push_back(cyc);
            check("ack_with_valid", 32'(rec_valid), 32'd1);
        end
        if (reset) begin
            stall_pend = 1'b0;
            rdy_run    = 0;
        end else begin
            if (stall_pend) begin
                check("stall_rdy", 32'(sample_rdy), 32'd1);
                check("stall_sample", 32'(sample), 32'(stall_val));
            end
            stall_pend = sample_rdy && !sample_ack;
            stall_val  = sample;
            if (sample_rdy) begin
                rdy_run++;
                if (rdy_run > max_run) max_run = rdy_run;
            end else begin
                rdy_run = 0;
            end
            if (sample_rdy && sample_ack) begin
                bytes_xfer++;
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL byte: actual %h required none", sample);
                end else begin
                    check("byte", 32'(sample), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        reset = 1'b1; enable = 1'b1; sample_ack = 1'b1;
        push_rec(48'h0605_0403_0201);

        // Reset holds everything quiet even with a record waiting.
        repeat (3) begin
            @(negedge clk);
            check("rst_sample_rdy", 32'(sample_rdy), 32'd0);
            check("rst_rec_ack", 32'(rec_ack), 32'd0);
            check("rst_records_sent", records_sent, 32'd0);
            check("rst_sample", 32'(sample), 32'h00);
            check("rst_busy", 32'(busy), 32'd0);
        end
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("ack_after_release", 32'(rec_ack), 32'd1);
        wait_done(0, 1'b0);
        check("single_records_sent", records_sent, 32'd1);
        check("single_ack_cnt", 32'(ack_cnt), 32'd1);

        // Back-to-back records, no bubbles.
        ack_cyc.delete(); max_run = 0; base_ack = ack_cnt;
        @(posedge clk); #1;
        push_rec(48'h1615_1413_1211);
        push_rec(48'h2625_2423_2221);
        push_rec(48'h3635_3433_3231);
        wait_done(0, 1'b0);
        check("b2b_ack_cnt", 32'(ack_cnt - base_ack), 32'd3);
        if (ack_cyc.size() >= 3) begin
            check("b2b_ack_gap1", 32'(ack_cyc[1] - ack_cyc[0]), 32'd6);
            check("b2b_ack_gap2", 32'(ack_cyc[2] - ack_cyc[1]), 32'd6);
        end else begin
            n_checks++; n_fail++;
            $display("FAIL b2b_ack_log: actual %0d pulses required 3", ack_cyc.size());
        end
        check("b2b_max_run", 32'(max_run), 32'd18);
        check("b2b_records_sent", records_sent, 32'd4);

        // Random backpressure over four records.
        base_ack = ack_cnt;
        @(posedge clk); #1;
        push_rec(48'hA5A5_5A5A_FF00);
        push_rec(48'h0123_4567_89AB);
        push_rec(48'hFEDC_BA98_7654);
        push_rec(48'h8001_8002_8003);
        wait_done(0, 1'b1);
        check("bp_ack_cnt", 32'(ack_cnt - base_ack), 32'd4);
        check("bp_records_sent", records_sent, 32'd8);

        // Enable dropped mid-record gates only the next load.
        base_ack = ack_cnt; base_bytes = bytes_xfer;
        @(posedge clk); #1;
        push_rec(48'h4645_4443_4241);
        push_rec(48'h5655_5453_5251);
        wait_bytes(base_bytes + 2); #1 enable = 1'b0;
        wait_done(6, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("gate_ack_cnt", 32'(ack_cnt - base_ack), 32'd1);
        check("gate_rec_valid", 32'(rec_valid), 32'd1);
        check("gate_sample_rdy", 32'(sample_rdy), 32'd0);
        check("gate_records_sent", records_sent, 32'd9);
        enable = 1'b1;
        @(negedge clk);
        check("gate_ack_on_enable", 32'(rec_ack), 32'd1);
        wait_done(0, 1'b0);
        check("gate_ack_total", 32'(ack_cnt - base_ack), 32'd2);
        check("gate_records_final", records_sent, 32'd10);

        // Counter wrap.
        @(posedge clk); #1;
        force dut.records_sent_q = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        release dut.records_sent_q;
        check("wrap_preload", records_sent, 32'hFFFF_FFFF);
        push_rec(48'h6665_6463_6261);
        wait_done(0, 1'b0);
        check("wrap_records_sent", records_sent, 32'h0000_0000);

        // Reset mid-record discards the partial record.
        base_bytes = bytes_xfer;
        @(posedge clk); #1;
        push_rec(48'h7675_7473_7271);
        push_rec(48'h8685_8483_8281);
        wait_bytes(base_bytes + 3); #1 reset = 1'b1;
        #1;
        check("midrst_sample_rdy", 32'(sample_rdy), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_sample", 32'(sample), 32'h00);
        repeat (3) exp_q.delete(0);
        @(posedge clk); @(posedge clk); #1 reset = 1'b0;
        base_ack = ack_cnt;
        @(negedge clk);
        check("restart_ack", 32'(rec_ack), 32'd1);
        wait_done(0, 1'b0);
        check("restart_ack_cnt", 32'(ack_cnt - base_ack), 32'd1);
        check("restart_records_sent", records_sent, 32'd1);
        check("restart_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
